// File: rtl/timer_counter_ctrl.sv
// timer_counter_ctrl
// Sequencing controller for the timer's 64-bit count datapath. It owns the
// count register and the 8-bit prescaler, decides on which cycles the count
// advances, is cleared or is loaded, and runs the debug-halt handshake.
//
// Build option: define TIMER_DBG_HALT_EN to include the HALTED state and the
// halt_req/dbg_mode handshake. Without it the FSM is IDLE/RUN only,
// halt_req and dbg_mode are ignored, and halt_ack_status is tied to 0.
//
// Ports
//   sys_clk            in   clock, rising edge
//   sys_rst_n          in   asynchronous active-low reset
//   timer_en           in   count enable (level)
//   div_en             in   prescaler enable (level)
//   div_val[3:0]       in   prescale exponent, period 2^div_val (saturates at 8)
//   halt_req           in   debug halt request (level)
//   dbg_mode           in   debugger attached; qualifies halt_req
//   counter_clear      in   one-cycle pulse, clears count and prescaler
//   counter_write_sel  in   bit0 loads cnt_val[31:0], bit1 loads cnt_val[63:32]
//   counter_write_data in   load data
//   cnt_val[63:0]      out  registered count
//   cnt_tick           out  registered, one cycle after each increment
//   halt_ack_status    out  registered, high while HALTED
module timer_counter_ctrl (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        timer_en,
  input  logic        div_en,
  input  logic [3:0]  div_val,
  input  logic        halt_req,
  input  logic        dbg_mode,
  input  logic        counter_clear,
  input  logic [1:0]  counter_write_sel,
  input  logic [31:0] counter_write_data,
  output logic [63:0] cnt_val,
  output logic        cnt_tick,
  output logic        halt_ack_status
);

`ifdef TIMER_DBG_HALT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALTED = 2'd2} state_e;
`else
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
`endif

  state_e      state_q, state_d;
  logic [7:0]  presc_q, presc_d;
  logic [63:0] cnt_q, cnt_d;
  logic        tick_q, tick_d;
  logic        div_en_q;
  logic [3:0]  div_val_q;

  logic [3:0]  div_sat;
  logic [8:0]  period;
  logic        use_presc;
  logic        presc_last;
  logic        cfg_chg;
  logic        inc;

  // Increment qualification; div_val of 0 degenerates to "every cycle".
  always_comb begin
    div_sat    = (div_val > 4'd8) ? 4'd8 : div_val;
    period     = 9'd1 << div_sat;
    use_presc  = div_en && (div_sat != 4'd0);
    presc_last = ({1'b0, presc_q} == (period - 9'd1));
    cfg_chg    = (div_en != div_en_q) || (div_val != div_val_q);
    inc        = (state_q == RUN) && (!use_presc || presc_last);
  end

  // Next state: every state follows timer_en unless a qualified halt is
  // present, which overrides all other transitions.
  always_comb begin
    state_d = timer_en ? RUN : IDLE;
`ifdef TIMER_DBG_HALT_EN
    if (halt_req && dbg_mode) begin
      state_d = HALTED;
    end
`endif
  end

  // Prescaler: cleared in IDLE, on clear or on a divider change; outside
  // RUN and IDLE (i.e. HALTED) it holds so the phase survives a halt.
  always_comb begin
    presc_d = presc_q;
    if ((state_q == IDLE) || counter_clear || cfg_chg) begin
      presc_d = '0;
    end else if (state_q == RUN) begin
      presc_d = inc ? '0 : presc_q + 8'd1;
    end
  end

  // Count update: clear > load > increment. A load swallows the increment.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (counter_clear) begin
      cnt_d = '0;
    end else if (counter_write_sel != 2'b00) begin
      if (counter_write_sel[0]) cnt_d[31:0]  = counter_write_data;
      if (counter_write_sel[1]) cnt_d[63:32] = counter_write_data;
    end else if (inc) begin
      cnt_d  = cnt_q + 64'd1;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      div_en_q  <= 1'b0;
      div_val_q <= '0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      div_en_q  <= div_en;
      div_val_q <= div_val;
    end
  end

`ifdef TIMER_DBG_HALT_EN
  logic ack_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= (state_d == HALTED);
    end
  end

  assign halt_ack_status = ack_q;
`else
  logic unused_dbg;
  assign unused_dbg      = halt_req ^ dbg_mode;
  assign halt_ack_status = 1'b0;
`endif

  assign cnt_val  = cnt_q;
  assign cnt_tick = tick_q;

endmodule

// File: tb/tb_timer_counter_ctrl.sv
module tb_timer_counter_ctrl;

`ifdef TIMER_DBG_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        sys_clk;
  logic        sys_rst_n;
  logic        timer_en;
  logic        div_en;
  logic [3:0]  div_val;
  logic        halt_req;
  logic        dbg_mode;
  logic        counter_clear;
  logic [1:0]  counter_write_sel;
  logic [31:0] counter_write_data;
  logic [63:0] cnt_val;
  logic        cnt_tick;
  logic        halt_ack_status;

  timer_counter_ctrl dut (
    .sys_clk            (sys_clk),
    .sys_rst_n          (sys_rst_n),
    .timer_en           (timer_en),
    .div_en             (div_en),
    .div_val            (div_val),
    .halt_req           (halt_req),
    .dbg_mode           (dbg_mode),
    .counter_clear      (counter_clear),
    .counter_write_sel  (counter_write_sel),
    .counter_write_data (counter_write_data),
    .cnt_val            (cnt_val),
    .cnt_tick           (cnt_tick),
    .halt_ack_status    (halt_ack_status)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: mode 0 = idle, 1 = run, 2 = halted.
  int          m_mode;
  int unsigned m_phase;
  logic [63:0] m_cnt;
  bit          m_tick;
  bit          m_ack;
  bit          m_prev_de;
  logic [3:0]  m_prev_dv;

  task automatic model_reset();
    m_mode    = 0;
    m_phase   = 0;
    m_cnt     = '0;
    m_tick    = 0;
    m_ack     = 0;
    m_prev_de = 0;
    m_prev_dv = '0;
  endtask

  task automatic model_clk();
    int unsigned e, per;
    bit          fire, hold;
    e    = (div_val > 4'd8) ? 8 : int'(div_val);
    per  = (div_en && e != 0) ? (32'd1 << e) : 1;
    hold = HALT_EN && halt_req && dbg_mode;
    fire = (m_mode == 1) && (per == 1 || m_phase == per - 1);
    if (m_mode == 0 || counter_clear || div_en != m_prev_de || div_val != m_prev_dv)
      m_phase = 0;
    else if (m_mode == 1)
      m_phase = fire ? 0 : m_phase + 1;
    if (counter_clear) begin
      m_cnt  = '0;
      m_tick = 0;
    end else if (counter_write_sel != 2'b00) begin
      if (counter_write_sel[0]) m_cnt[31:0]  = counter_write_data;
      if (counter_write_sel[1]) m_cnt[63:32] = counter_write_data;
      m_tick = 0;
    end else if (fire) begin
      m_cnt  = m_cnt + 64'd1;
      m_tick = 1;
    end else begin
      m_tick = 0;
    end
    m_mode    = hold ? 2 : (timer_en ? 1 : 0);
    m_ack     = (m_mode == 2);
    m_prev_de = div_en;
    m_prev_dv = div_val;
  endtask

  task automatic exp(input string name, input logic [63:0] c, input logic t, input logic a);
    n_chk++;
    if (cnt_val !== c) begin
      n_fail++;
      $display("FAIL %s cnt_val: got %h want %h @%0t", name, cnt_val, c, $time);
    end
    n_chk++;
    if (cnt_tick !== t) begin
      n_fail++;
      $display("FAIL %s cnt_tick: got %b want %b @%0t", name, cnt_tick, t, $time);
    end
    n_chk++;
    if (halt_ack_status !== a) begin
      n_fail++;
      $display("FAIL %s halt_ack_status: got %b want %b @%0t", name, halt_ack_status, a, $time);
    end
  endtask

  task automatic exp_int(input string name, input int act, input int want);
    n_chk++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_clk();
    #1;
    exp("model", m_cnt, m_tick, m_ack);
  endtask

  task automatic step(input logic en, input logic de, input logic [3:0] dv,
                      input logic hr, input logic dm, input logic clr,
                      input logic [1:0] ws, input logic [31:0] wd);
    timer_en           = en;
    div_en             = de;
    div_val            = dv;
    halt_req           = hr;
    dbg_mode           = dm;
    counter_clear      = clr;
    counter_write_sel  = ws;
    counter_write_data = wd;
    tick();
  endtask

  task automatic drive_idle();
    timer_en           = 1'b0;
    div_en             = 1'b0;
    div_val            = '0;
    halt_req           = 1'b0;
    dbg_mode           = 1'b0;
    counter_clear      = 1'b0;
    counter_write_sel  = '0;
    counter_write_data = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    exp("reset", 64'd0, 1'b0, 1'b0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 2'b00, 32'h0);
  endtask

  typedef struct {
    logic        en, de;
    logic [3:0]  dv;
    logic        hr, dm, clr;
    logic [1:0]  ws;
    logic [31:0] wd;
    logic [63:0] ec;
    logic        et, ea;
  } vec_t;

  vec_t vt[22];

  initial begin
    int first, ticks;
    logic [63:0] ec;

    // en de dv hr dm clr ws wd | cnt tick ack
    vt[0]  = '{1'b1,1'b0,4'd0,1'b0,1'b0,1'b0,2'b00,32'h0,        64'h0,                 1'b0,1'b0};
    vt[1]  = '{1'b1,1'b0,4'd0,1'b0,1'b0,1'b0,2'b00,32'h0,        64'h1,                 1'b1,1'b0};
    vt[2]  = '{1'b1,1'b0,4'd0,1'b0,1'b0,1'b0,2'b00,32'h0,        64'h2,                 1'b1,1'b0};
    vt[3]  = '{1'b1,1'b0,4'd0,1'b0,1'b0,1'b1,2'b00,32'h0,        64'h0,                 1'b0,1'b0};
    vt[4]  = '{1'b1,1'b0,4'd0,1'b0,1'b0,1'b0,2'b01,32'h5,        64'h5,                 1'b0,1'b0};
    vt[5]  = '{1'b1,1'b0,4'd0,1'b0,1'b0,1'b0,2'b10,32'hA,        64'hA_0000_0005,       1'b0,1'b0};
    vt[6]  = '{1'b1,1'b0,4'd0,1'b0,1'b0,1'b0,2'b00,32'h0,        64'hA_0000_0006,       1'b1,1'b0};
    vt[7]  = '{1'b0,1'b0,4'd0,1'b0,1'b0,1'b0,2'b00,32'h0,        64'hA_0000_0007,       1'b1,1'b0};
    vt[8]  = '{1'b0,1'b0,4'd0,1'b0,1'b0,1'b0,2'b00,32'h0,        64'hA_0000_0007,       1'b0,1'b0};
    vt[9]  = '{1'b0,1'b0,4'd0,1'b0,1'b0,1'b0,2'b11,32'hFFFF_FFFF,64'hFFFF_FFFF_FFFF_FFFF,1'b0,1'b0};
    vt[10] = '{1'b1,1'b0,4'd0,1'b0,1'b0,1'b0,2'b00,32'h0,        64'hFFFF_FFFF_FFFF_FFFF,1'b0,1'b0};
    vt[11] = '{1'b1,1'b0,4'd0,1'b0,1'b0,1'b0,2'b00,32'h0,        64'h0,                 1'b1,1'b0};
    vt[12] = '{1'b1,1'b0,4'd0,1'b0,1'b0,1'b1,2'b11,32'h1234,     64'h0,                 1'b0,1'b0};
    vt[13] = '{1'b1,1'b0,4'd0,1'b0,1'b0,1'b0,2'b00,32'h0,        64'h1,                 1'b1,1'b0};
    vt[14] = '{1'b1,1'b0,4'd0,1'b1,1'b0,1'b0,2'b00,32'h0,        64'h2,                 1'b1,1'b0};
    vt[15] = '{1'b1,1'b1,4'd1,1'b0,1'b0,1'b0,2'b00,32'h0,        64'h2,                 1'b0,1'b0};
    vt[16] = '{1'b1,1'b1,4'd1,1'b0,1'b0,1'b0,2'b00,32'h0,        64'h2,                 1'b0,1'b0};
    vt[17] = '{1'b1,1'b1,4'd1,1'b0,1'b0,1'b0,2'b00,32'h0,        64'h3,                 1'b1,1'b0};
    vt[18] = '{1'b1,1'b1,4'd1,1'b0,1'b0,1'b0,2'b00,32'h0,        64'h3,                 1'b0,1'b0};
    vt[19] = '{1'b1,1'b1,4'd1,1'b0,1'b0,1'b0,2'b00,32'h0,        64'h4,                 1'b1,1'b0};
    vt[20] = '{1'b1,1'b1,4'd15,1'b0,1'b0,1'b0,2'b00,32'h0,       64'h4,                 1'b0,1'b0};
    vt[21] = '{1'b1,1'b1,4'd0,1'b0,1'b0,1'b0,2'b00,32'h0,        64'h5,                 1'b1,1'b0};

    do_reset();
    for (int i = 0; i < 22; i++) begin
      step(vt[i].en, vt[i].de, vt[i].dv, vt[i].hr, vt[i].dm, vt[i].clr, vt[i].ws, vt[i].wd);
      exp($sformatf("vec%0d", i), vt[i].ec, vt[i].et, vt[i].ea);
    end

    // Free-running count, no prescaler.
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      step(1, 0, 0, 0, 0, 0, 2'b00, 32'h0);
      exp($sformatf("run%0d", i), 64'(i - 1), (i >= 2), 1'b0);
    end

    // Prescaler /8, then switch to /2 mid-run.
    do_reset();
    first = 0;
    ticks = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1, 1, 4'd3, 0, 0, 0, 2'b00, 32'h0);
      if (cnt_tick) begin
        ticks++;
        if (first == 0) first = i;
      end
    end
    exp_int("div8_ticks", ticks, 4);
    exp_int("div8_first", first, 9);
    first = 0;
    ticks = 0;
    for (int i = 41; i <= 50; i++) begin
      step(1, 1, 4'd1, 0, 0, 0, 2'b00, 32'h0);
      if (cnt_tick) begin
        ticks++;
        if (first == 0) first = i;
      end
    end
    exp_int("div2_ticks", ticks, 4);
    exp_int("div2_first", first, 43);

    // Wrap and partial loads.
    do_reset();
    step(1, 0, 0, 0, 0, 0, 2'b11, 32'hFFFF_FFFF);
    exp("load_ones", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    step(1, 0, 0, 0, 0, 0, 2'b00, 32'h0);
    exp("wrap", 64'h0, 1'b1, 1'b0);
    step(1, 0, 0, 0, 0, 0, 2'b10, 32'hAB);
    exp("load_hi", 64'hAB_0000_0000, 1'b0, 1'b0);
    step(1, 0, 0, 0, 0, 0, 2'b00, 32'h0);
    exp("inc_after_hi", 64'hAB_0000_0001, 1'b1, 1'b0);
    step(1, 0, 0, 0, 0, 0, 2'b01, 32'h5);
    exp("load_lo_tick", 64'hAB_0000_0005, 1'b0, 1'b0);
    step(1, 0, 0, 0, 0, 0, 2'b00, 32'h0);
    exp("inc_after_lo", 64'hAB_0000_0006, 1'b1, 1'b0);
    step(1, 0, 0, 0, 0, 1, 2'b11, 32'h77);
    exp("clr_over_load", 64'h0, 1'b0, 1'b0);

    // Halt with /4 prescaler; phase survives the halt.
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      step(1, 1, 4'd2, 0, 0, 0, 2'b00, 32'h0);
      if (i == 5) exp("pre_halt5", 64'd1, 1'b1, 1'b0);
    end
    exp("pre_halt10", 64'd2, 1'b0, 1'b0);
    step(1, 1, 4'd2, 1, 1, 0, 2'b00, 32'h0);
    exp("halt_ack", 64'd2, 1'b0, HALT_EN);
    for (int i = 12; i <= 15; i++) step(1, 1, 4'd2, 1, 1, 0, 2'b00, 32'h0);
    exp("halted", HALT_EN ? 64'd2 : 64'd3, 1'b0, HALT_EN);
    step(1, 1, 4'd2, 0, 1, 0, 2'b00, 32'h0);
    exp("release", HALT_EN ? 64'd2 : 64'd3, 1'b0, 1'b0);
    step(1, 1, 4'd2, 0, 1, 0, 2'b00, 32'h0);
    exp("resume17", HALT_EN ? 64'd2 : 64'd4, HALT_EN ? 1'b0 : 1'b1, 1'b0);
    step(1, 1, 4'd2, 0, 1, 0, 2'b00, 32'h0);
    exp("resume18", HALT_EN ? 64'd3 : 64'd4, HALT_EN ? 1'b1 : 1'b0, 1'b0);
    step(1, 1, 4'd2, 1, 0, 0, 2'b00, 32'h0);
    exp("no_dbg", HALT_EN ? 64'd3 : 64'd4, 1'b0, 1'b0);
    step(1, 1, 4'd2, 1, 1, 0, 2'b00, 32'h0);
    exp("halt_again", HALT_EN ? 64'd3 : 64'd4, 1'b0, HALT_EN);

    // Asynchronous reset between clock edges.
    #2;
    sys_rst_n = 1'b0;
    #1;
    exp("async_rst", 64'd0, 1'b0, 1'b0);
    drive_idle();
    model_reset();
    @(posedge sys_clk);
    #1;
    exp("rst_held", 64'd0, 1'b0, 1'b0);
    sys_rst_n = 1'b1;
    step(1, 0, 0, 0, 0, 0, 2'b00, 32'h0);
    exp("restart0", 64'd0, 1'b0, 1'b0);
    step(1, 0, 0, 0, 0, 0, 2'b00, 32'h0);
    exp("restart1", 64'd1, 1'b1, 1'b0);

    // Randomized traffic checked by the model inside tick().
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) timer_en = ~timer_en;
      if ($urandom_range(0, 29) == 0) halt_req = ~halt_req;
      if ($urandom_range(0, 39) == 0) dbg_mode = ~dbg_mode;
      if ($urandom_range(0, 59) == 0) div_en = ~div_en;
      if ($urandom_range(0, 79) == 0)
        div_val = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
      counter_clear     = ($urandom_range(0, 149) == 0);
      counter_write_sel = ($urandom_range(0, 49) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      counter_write_data = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'($urandom);
      tick();
    end
    ec = m_cnt;
    exp("random_end", ec, m_tick, m_ack);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_counter_ctrl.md
# timer_counter_ctrl

Sequencing controller for the timer's 64-bit count datapath. It owns the count register and prescaler and decides on which cycles the count advances, is cleared or is loaded. It also runs the debug-halt request/acknowledge handshake. It sits between the register block, which supplies control and command strobes, and the interrupt block, which consumes `cnt_val`.

## Interface
- No parameters. Widths are fixed: 64-bit count, 4-bit divider select, 8-bit prescaler.
- `sys_clk` in 1: the only clock; everything is on the rising edge.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `timer_en` in 1: count enable, level (TCR bit 0).
- `div_en` in 1: prescaler enable, level.
- `div_val` in 4: prescale exponent, giving a period of 2^div_val cycles.
- `halt_req` in 1: debug halt request, level.
- `dbg_mode` in 1: debugger attached; a halt is honoured only while this is high.
- `counter_clear` in 1: single-cycle pulse that clears count and prescaler.
- `counter_write_sel` in 2: bit 0 loads `cnt_val[31:0]`, bit 1 loads `cnt_val[63:32]`.
- `counter_write_data` in 32: load data.
- `cnt_val` out 64: registered count.
- `cnt_tick` out 1: registered; high for one cycle when `cnt_val` has just incremented.
- `halt_ack_status` out 1: registered; high while in HALTED.

## Operation
- Reset values:
  - `cnt_val` = 0, `cnt_tick` = 0, `halt_ack_status` = 0.
  - Prescaler = 0, state = IDLE.
- FSM states and transitions:
  - IDLE → RUN when `timer_en`=1.
  - IDLE → HALTED when `halt_req && dbg_mode`.
  - RUN → IDLE when `timer_en`=0.
  - RUN → HALTED when `halt_req && dbg_mode`. This takes priority over `timer_en` falling.
  - HALTED → RUN when `!(halt_req && dbg_mode)` and `timer_en`=1.
  - HALTED → IDLE when `!(halt_req && dbg_mode)` and `timer_en`=0.
- Increment condition: the count advances only in RUN.
  - `div_en`=0: the count increments every RUN cycle.
  - `div_en`=1: the prescaler counts 0..2^div_val−1 and the count increments on the cycle the prescaler equals 2^div_val−1, after which the prescaler wraps to 0.
  - `div_val` of 0 behaves as `div_en`=0.
  - `div_val` > 8 is saturated to 8.
- Prescaler resets to 0 on any of:
  - state is IDLE;
  - `counter_clear`;
  - `div_en` or `div_val` differs from its value on the previous cycle.
- Prescaler is held (frozen, not reset) in HALTED.
- Update priority per cycle, highest first:
  1. `counter_clear`: `cnt_val` ← 0.
  2. `counter_write_sel`: the selected word(s) are loaded. Both bits set loads `counter_write_data` into both halves. A pending increment in that cycle is dropped.
  3. Increment: `cnt_val` ← `cnt_val` + 1, modulo 2^64. `64'hFFFF_FFFF_FFFF_FFFF` wraps to 0 with `cnt_tick`=1.
- Writes and clears are accepted in every state, including IDLE and HALTED.
- `cnt_tick` is never asserted in a cycle following a clear or a load.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- `timer_en` rises in cycle k, giving state RUN at k+1.
  - `div_en`=0: first increment visible at k+2.
  - `div_en`=1: first increment visible at k+1+2^div_val.
- `halt_req && dbg_mode` sampled high in cycle k gives `halt_ack_status`=1 at k+1. No increment is visible from k+1.
- Deassertion in cycle k gives `halt_ack_status`=0 at k+1. Counting resumes from the frozen prescaler value.
- A clear or load in cycle k is visible on `cnt_val` at k+1.
- Asserting `sys_rst_n` low mid-count immediately forces every output and the FSM to its reset value.

## Configuration
- `TIMER_DBG_HALT_EN` defined: the HALTED state and handshake are present as described above.
- `TIMER_DBG_HALT_EN` undefined:
  - HALTED is removed;
  - `halt_req` and `dbg_mode` are ignored;
  - `halt_ack_status` is tied to 0;
  - the FSM is IDLE/RUN only.

## Test plan
- Reset, then `timer_en`=1 with `div_en`=0 for 10 cycles → `cnt_val`=9 at the 10th cycle, `cnt_tick` high on every increment.
- `div_en`=1, `div_val`=3, `timer_en`=1 for 40 cycles → 4 increments spaced 8 cycles apart; changing `div_val` to 1 mid-run restarts the prescaler with increments every 2 cycles.
- Load 0xFFFF_FFFF to both words, then run → `cnt_val` = 0 after one increment with `cnt_tick`=1; `counter_write_sel`=2'b01 with data 0x5 in a tick cycle → low word = 5, high word unchanged, no increment.
- `counter_clear` and `counter_write_sel`=2'b11 in the same cycle → `cnt_val`=0 next cycle.
- Running with `div_val`=2: `halt_req`=1, `dbg_mode`=1 → `halt_ack_status`=1 next cycle and `cnt_val` frozen; release → resumes with the prescaler phase preserved. `halt_req`=1 with `dbg_mode`=0 → no halt.
- Pull `sys_rst_n` low mid-count while HALTED → all outputs 0 asynchronously; restart from IDLE.
